// File: rtl/rtl_settings_pkg.sv
// rtl_settings_pkg: address modes, generator states and LFSR sizing helpers
package rtl_settings_pkg;
  typedef enum logic [2:0] {
    MODE_FIX   = 3'd0,
    MODE_RND   = 3'd1,
    MODE_RUN_0 = 3'd2,
    MODE_RUN_1 = 3'd3,
    MODE_INC   = 3'd4,
    MODE_DEC   = 3'd5,
    MODE_RSV6  = 3'd6,
    MODE_RSV7  = 3'd7
  } addr_mode_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} gen_state_t;
  function automatic int lfsr_width(int aw);
    return aw <= 8 ? 8 : aw <= 16 ? 16 : aw <= 24 ? 24 : 32;
  endfunction
  // tap n sits at mask bit n-1
  function automatic logic [31:0] lfsr_taps(int w);
    return w == 8 ? 32'h0000_00B8 : w == 16 ? 32'h0000_D008 :
           w == 24 ? 32'h00E1_0000 : 32'h8020_0003;
  endfunction
endpackage

// File: rtl/addr_gen_stream_lfsr.sv
// addr_lfsr: Fibonacci LFSR, shifts left with XOR feedback into bit 0; zero loads become all-ones
module addr_lfsr #(
  parameter int WIDTH = 8,
  parameter logic [31:0] TAPS = 32'h0000_00B8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);
  logic fb;
  assign fb = ^(state_o & TAPS[WIDTH-1:0]);
  always_ff @(posedge clk_i) begin
    if (rst_i) state_o <= '1;
    else if (load_i) state_o <= seed_i == '0 ? '1 : seed_i;
    else if (step_i) state_o <= {state_o[WIDTH-2:0], fb};
  end
endmodule

// File: rtl/addr_gen_stream.sv
// addr_gen_stream: moded address generator with valid/ready stream, last and done
// ADDR_GEN_SEED_EN adds cfg_seed_i; otherwise the LFSR restarts from all-ones each run
module addr_gen_stream
  import rtl_settings_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STEP_W = 16,
  parameter int CNT_W = 32,
  localparam int LFSR_W = lfsr_width(ADDR_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  addr_mode_t        cfg_mode_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [STEP_W-1:0] cfg_step_i,
  input  logic [CNT_W-1:0]  cfg_count_i,
`ifdef ADDR_GEN_SEED_EN
  input  logic [LFSR_W-1:0] cfg_seed_i,
`endif
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_last_o,
  output logic              busy_o,
  output logic              done_o
);
  gen_state_t state_q;
  addr_mode_t mode_q;
  logic [ADDR_W-1:0] step_q, addr_q, first_addr, next_addr;
  logic [CNT_W-1:0] count_q, cnt_q;
  logic [LFSR_W-1:0] lfsr_state, seed;
  logic valid_q, busy_q, done_q, accept, last, load;
`ifdef ADDR_GEN_SEED_EN
  assign seed = cfg_seed_i;
`else
  assign seed = '1;
`endif
  assign load = start_i && state_q == S_IDLE;
  assign accept = valid_q && addr_ready_i;
  assign last = cnt_q == count_q - CNT_W'(1);
  assign first_addr = cfg_mode_i inside {MODE_FIX, MODE_INC, MODE_DEC} ? cfg_base_i :
                      cfg_mode_i == MODE_RUN_0 ? ~ADDR_W'(1) :
                      cfg_mode_i == MODE_RUN_1 ? ADDR_W'(1) : '0;
  assign next_addr = mode_q == MODE_FIX ? addr_q :
                     mode_q == MODE_INC ? addr_q + step_q :
                     mode_q == MODE_DEC ? addr_q - step_q :
                     mode_q inside {MODE_RUN_0, MODE_RUN_1} ? {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]} : '0;
  addr_lfsr #(.WIDTH(LFSR_W), .TAPS(lfsr_taps(LFSR_W))) u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .seed_i (seed),
    .step_i (accept && mode_q == MODE_RND),
    .state_o(lfsr_state)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_FIX;
      step_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_i) begin
          mode_q  <= cfg_mode_i;
          step_q  <= ADDR_W'(cfg_step_i);
          count_q <= cfg_count_i;
          cnt_q   <= '0;
          addr_q  <= first_addr;
          busy_q  <= 1'b1;
          valid_q <= cfg_count_i != '0;
          done_q  <= cfg_count_i == '0;
          state_q <= cfg_count_i != '0 ? S_RUN : S_DONE;
        end
        S_RUN: if (accept) begin
          if (last) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            addr_q <= next_addr;
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
  assign addr_valid_o = valid_q;
  assign addr_o = mode_q == MODE_RND ? lfsr_state[ADDR_W-1:0] : addr_q;
  assign addr_last_o = valid_q && last;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_addr_gen_stream.sv
// tb_addr_gen_stream: scoreboard bench for addr_gen_stream at ADDR_W=8
module tb_addr_gen_stream;
  import rtl_settings_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  addr_mode_t mode = MODE_FIX;
  logic [7:0] base = '0;
  logic [15:0] step = '0;
  logic [31:0] count = '0;
  logic valid, last, busy, done;
  logic [7:0] addr;
  logic [8:0] exp_q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  addr_gen_stream #(.ADDR_W(8), .STEP_W(16), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .cfg_mode_i(mode),
    .cfg_base_i(base), .cfg_step_i(step), .cfg_count_i(count),
    .addr_valid_o(valid), .addr_ready_i(ready), .addr_o(addr),
    .addr_last_o(last), .busy_o(busy), .done_o(done)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_expected(addr_mode_t m, logic [7:0] b, logic [15:0] s, int n);
    logic [7:0] a, l;
    l = 8'hFF;
    a = m inside {MODE_FIX, MODE_INC, MODE_DEC} ? b : m == MODE_RUN_0 ? 8'hFE :
        m == MODE_RUN_1 ? 8'h01 : m == MODE_RND ? l : 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i == n - 1, a});
      if (m == MODE_INC) a = a + s[7:0];
      else if (m == MODE_DEC) a = a - s[7:0];
      else if (m inside {MODE_RUN_0, MODE_RUN_1}) a = {a[6:0], a[7]};
      else if (m == MODE_RND) begin
        l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        a = l;
      end
    end
  endtask
  task automatic run(string name, addr_mode_t m, logic [7:0] b, logic [15:0] s, int n,
                     int stall_beat, int stall_len);
    int beats, stalls, cyc, last_acc;
    bit seen_done;
    beats = 0; stalls = 0; cyc = 0; last_acc = -1; seen_done = 0;
    push_expected(m, b, s, n);
    @(negedge clk);
    mode = m; base = b; step = s; count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base = 8'hA5; step = 16'h0033; count = 7; mode = MODE_INC;
    check({name, "_busy_start"}, busy, 1);
    while (!seen_done && cyc < n + stall_len + 4) begin
      start = cyc == 1;
      ready = !(beats == stall_beat && stalls < stall_len);
      if (done) begin
        seen_done = 1;
        check({name, "_done_timing"}, cyc, last_acc + 1);
        check({name, "_done_busy"}, busy, 1);
        check({name, "_done_left"}, exp_q.size(), 0);
      end
      if (valid && exp_q.size() == 0) check({name, "_unexpected_valid"}, valid, 0);
      else if (valid && ready) begin
        check({name, "_addr"}, addr, exp_q[0][7:0]);
        check({name, "_last"}, last, exp_q[0][8]);
        void'(exp_q.pop_front());
        beats++;
        last_acc = cyc;
      end else if (valid) begin
        check({name, "_stall_addr"}, addr, exp_q[0][7:0]);
        stalls++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (!seen_done) check({name, "_done_timeout"}, 0, 1);
    check({name, "_idle_done"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_idle_valid"}, valid, 0);
    exp_q.delete();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", valid, 0);
    check("rst_addr", addr, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    run("inc", MODE_INC, 8'h10, 16'd4, 3, -1, 0);
    run("dec_wrap", MODE_DEC, 8'h02, 16'd3, 3, -1, 0);
    run("run1_stall", MODE_RUN_1, 8'h00, 16'd0, 3, 1, 3);
    run("run0", MODE_RUN_0, 8'h00, 16'd0, 9, 4, 2);
    run("fix", MODE_FIX, 8'h5A, 16'd9, 2, 0, 1);
    run("cnt0", MODE_INC, 8'h10, 16'd1, 0, -1, 0);
    run("rnd_a", MODE_RND, 8'h00, 16'd0, 4, -1, 0);
    run("rnd_b", MODE_RND, 8'h00, 16'd0, 4, 2, 2);
    run("rsv", MODE_RSV6, 8'h77, 16'd1, 2, -1, 0);
    run("inc_wrap", MODE_INC, 8'hF0, 16'h0120, 3, -1, 0);
    @(negedge clk);
    mode = MODE_INC; base = 8'h00; step = 16'd1; count = 10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_addr", addr, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    check("mid_rst_nodone", done, 0);
    check("mid_rst_novalid", valid, 0);
    run("after_rst", MODE_INC, 8'h40, 16'd2, 3, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
